// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word/RAM-state types plus arbiter FSM and op enums.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
    typedef enum logic [1:0] {IDLE, ISSUE, RETRY, DONE} arb_state_t;
    typedef enum logic [1:0] {IREAD, DREAD, DWRITE} op_t;
    localparam word_t BAD_LOAD = 32'hBAD0BAD0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr_i.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);
    logic [IW-1:0] lo, hi;
    logic          hi_v;
    // lo = lowest requester overall (wrap case), hi = lowest at/after the pointer
    always_comb begin
        lo   = '0;
        hi   = '0;
        hi_v = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) lo = IW'(i);
            if (req_i[i] && IW'(i) >= ptr_i) begin
                hi   = IW'(i);
                hi_v = 1'b1;
            end
        end
    end
    assign idx_o = hi_v ? hi : lo;
    assign gnt_o = |req_i ? N'(1) << idx_o : '0;
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises per-CPU instruction/data requests onto one RAM port
// and returns wait pulses and registered load data to each requesting cache.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [CPUS-1:0]   iREN,
    input  logic [CPUS-1:0]   dREN,
    input  logic [CPUS-1:0]   dWEN,
    input  logic [32*CPUS-1:0] iaddr,
    input  logic [32*CPUS-1:0] daddr,
    input  logic [32*CPUS-1:0] dstore,
    output logic [CPUS-1:0]   iwait,
    output logic [CPUS-1:0]   dwait,
    output logic [32*CPUS-1:0] iload,
    output logic [32*CPUS-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [31:0]       ramaddr,
    output logic [31:0]       ramstore,
    input  logic [31:0]       ramload,
    input  logic [1:0]        ramstate
);
    localparam int            IW   = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [7:0]    TO   = 8'(TIMEOUT);
    localparam logic [IW-1:0] LAST = IW'(CPUS - 1);

    word_t ia [CPUS];
    word_t da [CPUS];
    word_t ds [CPUS];
    word_t iload_q [CPUS];
    word_t iload_d [CPUS];
    word_t dload_q [CPUS];
    word_t dload_d [CPUS];

    arb_state_t      state_q, state_d;
    op_t             op_q, op_d, gop;
    logic [IW-1:0]   cpu_q, cpu_d, rr_q, rr_d, gidx;
    word_t           addr_q, addr_d, store_q, store_d, ld;
    logic            ren_q, ren_d, wen_q, wen_d, finish;
    logic [7:0]      cnt_q, cnt_d, cnt_inc;
    logic [CPUS-1:0] iwait_q, iwait_d, dwait_q, dwait_d, req_vec, gnt;
    ramstate_t       rs;

    for (genvar c = 0; c < CPUS; c++) begin : g_cpu
        assign ia[c]              = iaddr[c*32 +: 32];
        assign da[c]              = daddr[c*32 +: 32];
        assign ds[c]              = dstore[c*32 +: 32];
        assign iload[c*32 +: 32]  = iload_q[c];
        assign dload[c*32 +: 32]  = dload_q[c];
    end

    assign rs       = ramstate_t'(ramstate);
    assign gop      = |dWEN ? DWRITE : |dREN ? DREAD : IREAD;
    assign req_vec  = |dWEN ? dWEN : |dREN ? dREN : iREN;
    assign ld       = (rs == ACCESS) ? ramload : BAD_LOAD;
    assign cnt_inc  = cnt_q + 8'd1;
    assign finish   = (rs == ACCESS) || (rs != ERROR && cnt_inc >= TO);
    assign iwait    = iwait_q;
    assign dwait    = dwait_q;
    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    rr_arbiter #(.N(CPUS), .IW(IW)) u_rr (
        .req_i (req_vec),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gidx)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            op_q    <= IREAD;
            cpu_q   <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            store_q <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            cnt_q   <= '0;
            iwait_q <= '1;
            dwait_q <= '1;
            iload_q <= '{default: '0};
            dload_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cpu_q   <= cpu_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            cnt_q   <= cnt_d;
            iwait_q <= iwait_d;
            dwait_q <= dwait_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cpu_d   = cpu_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        store_d = store_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        cnt_d   = cnt_q;
        iwait_d = iwait_q;
        dwait_d = dwait_q;
        iload_d = iload_q;
        dload_d = dload_q;
        case (state_q)
            IDLE: if (|gnt) begin
                state_d = ISSUE;
                cpu_d   = gidx;
                op_d    = gop;
                addr_d  = (gop == IREAD) ? ia[gidx] : da[gidx];
                store_d = (gop == DWRITE) ? ds[gidx] : store_q;
                ren_d   = gop != DWRITE;
                wen_d   = gop == DWRITE;
                cnt_d   = '0;
            end
            ISSUE: begin
                cnt_d = (rs == ACCESS || rs == ERROR) ? cnt_q : cnt_inc;
                if (finish) begin
                    state_d = DONE;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    rr_d    = (cpu_q == LAST) ? '0 : cpu_q + 1'b1;
                    if (op_q == IREAD) begin
                        iwait_d[cpu_q] = 1'b0;
                        iload_d[cpu_q] = ld;
                    end else begin
                        dwait_d[cpu_q] = 1'b0;
                    end
                    // timed-out writes are simply dropped; only reads load data
                    if (op_q == DREAD) dload_d[cpu_q] = ld;
                end else if (rs == ERROR) begin
                    state_d = RETRY;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                end
            end
            RETRY: begin
                state_d = ISSUE;
                ren_d   = op_q != DWRITE;
                wen_d   = op_q == DWRITE;
            end
            DONE: begin
                state_d = IDLE;
                iwait_d = '1;
                dwait_d = '1;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Memory-side responder of the cache/controller interface.
- Accepts instruction-read, data-read and data-write requests from CPUS cache blocks and serialises them onto one single-port RAM.
- For each CPU it drives the iwait/dwait handshake and the iload/dload return data.
- Sits between the per-CPU cache blocks and the RAM model/controller.

Parameters:
- CPUS, 2, number of requesting cache blocks.
- TIMEOUT, 255, max cycles a RAM access may stay un-acknowledged before forced completion; 8-bit counter.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  CPUS  instruction read request, per CPU.
- dREN  in  CPUS  data read request, per CPU.
- dWEN  in  CPUS  data write request, per CPU.
- iaddr  in  32*CPUS  instruction address, per CPU.
- daddr  in  32*CPUS  data address, per CPU.
- dstore  in  32*CPUS  data write value, per CPU.
- iwait  out  CPUS  low for exactly one cycle when that CPU's instruction read completes.
- dwait  out  CPUS  low for exactly one cycle when that CPU's data access completes.
- iload  out  32*CPUS  registered instruction return, per CPU.
- dload  out  32*CPUS  registered data return, per CPU.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data; valid when ramstate = ACCESS.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Behaviour:
- Clock is CLK. Reset nRST is asynchronous and active-low.
- Reset values: state IDLE; iwait/dwait all 1; iload/dload all 0; ramREN/ramWEN 0; ramaddr/ramstore 0; rr pointer 0; timeout counter 0.
- All outputs are registered. Only state and latched grant fields drive them.
- FSM states: IDLE, ISSUE, RETRY, DONE.
- IDLE arbitration:
  - Class priority: dWEN > dREN > iREN (data before instruction).
  - Within a class, round-robin from the rr pointer.
  - The rr pointer advances to winner+1 (mod CPUS) on entry to DONE.
  - dREN and dWEN both high on one CPU: treat as a write.
  - No request: stay IDLE.
- Grant (IDLE -> ISSUE, at the edge where the request is sampled):
  - Latch cpu index, op type, address, and store data for writes.
  - ramREN or ramWEN asserts in the next cycle.
  - Clear the timeout counter.
- ISSUE:
  - Hold enables, address and data stable.
  - ramstate = ACCESS: for reads, capture ramload into iload[cpu] or dload[cpu]; go to DONE.
  - ramstate = ERROR: go to RETRY.
  - Otherwise increment the counter.
  - Counter reaches TIMEOUT: go to DONE with load = 32'hBAD0BAD0 on reads; writes are dropped.
- RETRY: enables deasserted for one cycle, then ISSUE with the same latched request. The counter is not cleared.
- DONE:
  - Enables deasserted; the served CPU's iwait or dwait is low for this single cycle.
  - Then IDLE.
  - Load registers hold their value until that port's next completion.
- Minimum latency: request sampled at edge E0, with ACCESS during the first ISSUE cycle:
  - wait is low in the cycle after E1;
  - back to IDLE at E2.
  - Peak throughput is one access per 3 cycles.
- Request withdrawn after grant: the access still completes and the wait pulse still issues. A write is never aborted.
- Address or data changes after grant: ignored; the latched values are used.
- Non-served CPUs keep wait = 1 throughout.
- Reset asserted mid-access: immediate return to reset values. No wait pulse is produced.

Decomposition:
- word_t and ramstate_t (FREE/BUSY/ACCESS/ERROR) live in cpu_types_pkg.
- Arbiter-local state enum and op-type enum (IREAD/DREAD/DWRITE) live in the same package.
- Sub-module rr_arbiter: CPUS-wide request vector plus pointer in, one-hot grant plus index out. Purely combinational. Instantiated once per class, or once on the class-masked vector.

Test Plan:
- CPU0 iREN, iaddr=0x0000_0040; RAM returns 0x8C01_0004 on the first ISSUE cycle -> ramREN=1, ramaddr=0x40 one cycle after sampling; iwait[0] low exactly one cycle; iload[0]=0x8C01_0004 held afterwards.
- CPU0 iREN and CPU1 dWEN (daddr=0x100, dstore=0xCAFEF00D) same cycle -> write served first (ramWEN=1, ramstore=0xCAFEF00D); dwait[1] pulses; then CPU0 read; iwait[0] pulses.
- Both CPUs dREN held continuously over 4 grants -> served order CPU0, CPU1, CPU0, CPU1.
- RAM returns ERROR once, then ACCESS with 0x1234_5678 -> one RETRY cycle with enables low, same address re-issued, dload correct, single dwait pulse.
- RAM stuck BUSY, TIMEOUT=4, dREN -> dwait pulse 4 cycles into ISSUE; dload=0xBAD0BAD0; FSM returns to IDLE.
- nRST pulsed low mid-ISSUE -> all waits 1, enables 0, loads 0 immediately; a fresh request after release is served normally.
